// File: rtl/des_round_sequencer.sv
// des_round_sequencer: iterative DES round controller driving an external f-function, one round per cycle.
// Optional abort input enabled by defining DES_SEQ_ABORT_EN.
module des_round_sequencer #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_block,
    input  logic [55:0] in_key,
    output logic [31:0] f_r,
    output logic [55:0] f_cd,
    input  logic [31:0] f_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_block,
    output logic        busy
`ifdef DES_SEQ_ABORT_EN
    ,
    input  logic        abort
`endif
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] l, r, f_r_q;
    logic [27:0] c, d;
    logic [55:0] cd_rot, f_cd_q;
    logic [4:0] round;
    logic [1:0] sh;
    logic decrypt, one, last, kill;

`ifdef DES_SEQ_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif

    // Decrypt rotates right; a zero shift only occurs in decrypt round 1.
    function automatic logic [27:0] rot(input logic [27:0] x, input logic dec, input logic [1:0] n);
        return dec ? (n == 2'd0 ? x : n == 2'd1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]})
                   : (n == 2'd1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]});
    endfunction

    assign one  = round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16;
    assign last = round == 5'(NUM_ROUNDS);

    always_comb begin
        sh     = decrypt ? (round == 5'd1 ? 2'd0 : one ? 2'd1 : 2'd2) : (one ? 2'd1 : 2'd2);
        cd_rot = {rot(c, decrypt, sh), rot(d, decrypt, sh)};
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = kill ? IDLE
                 : (state == IDLE && in_valid) ? ROUND
                 : (state == ROUND && last) ? DONE
                 : (state == DONE && out_ready) ? IDLE
                 : state;
    end

    always_comb begin
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        f_r       = state == ROUND ? r : f_r_q;
        f_cd      = state == ROUND ? cd_rot : f_cd_q;
        out_block = {r, l};
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            {l, r, c, d, round, decrypt} <= '0;
        end else if (state == IDLE && in_valid) begin
            {l, r}  <= in_block;
            {c, d}  <= in_key;
            decrypt <= in_decrypt;
            round   <= 5'd1;
        end else if (state == ROUND) begin
            l      <= r;
            r      <= l ^ f_result;
            {c, d} <= cd_rot;
            round  <= round + 5'd1;
        end
    end

    // Last values presented to the f-function stay visible outside ROUND.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_r_q  <= '0;
            f_cd_q <= '0;
        end else if (state == ROUND) begin
            f_r_q  <= r;
            f_cd_q <= cd_rot;
        end
    end
endmodule

// File: tb/tb_des_round_sequencer.sv
// tb_des_round_sequencer: scoreboard bench wrapping the sequencer with a full DES reference model.
module tb_des_round_sequencer;
    logic clk = 0, rst = 1, in_valid = 0, in_decrypt = 0, out_ready = 1;
    logic in_ready, out_valid, busy;
    logic [63:0] in_block = '0, out_block;
    logic [55:0] in_key = '0, f_cd;
    logic [31:0] f_r, f_result;
`ifdef DES_SEQ_ABORT_EN
    logic abort = 0;
`endif
    int compared = 0, mismatched = 0, cyc = 0;
    bit bp = 0, prev_ov = 0;
    typedef struct {logic [63:0] ct; int acc;} exp_t;
    exp_t q[$];

    int ip_t[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int e_t[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                     16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    logic [255:0] sbox_t [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    // Tables use DES numbering: bit 1 is the MSB of an in_w-bit value.
    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int t[$]);
        logic [63:0] y = '0;
        for (int i = 0; i < t.size(); i++) y[t.size() - 1 - i] = x[in_w - t[i]];
        return y;
    endfunction

    function automatic logic [47:0] subkey(input logic [55:0] cd);
        logic [63:0] t;
        t = perm({8'b0, cd}, 56, pc2_t);
        return t[47:0];
    endfunction

    function automatic logic [31:0] ffun(input logic [31:0] r, input logic [47:0] k);
        logic [63:0] e, s;
        logic [47:0] x;
        logic [5:0] six;
        int idx;
        e = perm({32'b0, r}, 32, e_t);
        x = e[47:0] ^ k;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            six = x[47 - 6 * j -: 6];
            idx = int'({six[5], six[0], six[4:1]});
            s[31 - 4 * j -: 4] = sbox_t[j][255 - 4 * idx -: 4];
        end
        e = perm(s, 32, p_t);
        return e[31:0];
    endfunction

    // Textbook DES: left-shift key schedule, decryption applies subkeys in reverse.
    function automatic logic [63:0] des(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        logic [47:0] ks [16];
        logic [63:0] t;
        logic [27:0] c, d;
        logic [31:0] l, r, tmp;
        t = perm(key, 64, pc1_t);
        c = t[55:28];
        d = t[27:0];
        for (int i = 1; i <= 16; i++) begin
            for (int s = 0; s < ((i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2); s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i - 1] = subkey({c, d});
        end
        t = perm(blk, 64, ip_t);
        l = t[63:32];
        r = t[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r = l ^ ffun(r, dec ? ks[15 - i] : ks[i]);
            l = tmp;
        end
        return perm({r, l}, 64, fp_t);
    endfunction

    assign f_result = ffun(f_r, subkey(f_cd));

    des_round_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
        .in_block(in_block), .in_key(in_key), .f_r(f_r), .f_cd(f_cd), .f_result(f_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
`ifdef DES_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each handshake.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) check("unexpected_valid", 1, 0);
                else check("latency", 64'(cyc), 64'(q[0].acc + 17));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("orphan_result", 1, 0);
                else begin
                    e = q.pop_front();
                    check("result", perm(out_block, 64, fp_t), e.ct);
                end
            end
        end
        prev_ov = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp) out_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic send(input logic [63:0] key, input logic [63:0] pt, input logic dec, input logic [63:0] ct);
        logic [63:0] t;
        int n = 0;
        t = perm(key, 64, pc1_t);
        in_key = t[55:0];
        in_block = perm(pt, 64, ip_t);
        in_decrypt = dec;
        in_valid = 1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("accept_wait", 64'(in_ready), 1);
        q.push_back('{ct, cyc});
        tick();
    endtask

    task automatic send_rand();
        logic [63:0] k, p;
        logic dec;
        k = {$urandom, $urandom};
        p = {$urandom, $urandom};
        dec = 1'($urandom_range(0, 1));
        send(k, p, dec, des(k, p, dec));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("idle_wait", 64'(busy), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 1);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_out_block"}, out_block, 0);
        check({tag, "_f_r"}, 64'(f_r), 0);
        check({tag, "_f_cd"}, 64'(f_cd), 0);
    endtask

    initial begin
        logic [63:0] t, hold;
        logic [55:0] cd_hold;
        int n;
        repeat (2) tick();
        check_reset("reset");
        rst = 0;
        tick();

        send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 0, 64'h85E813540F0AB405);
        in_valid = 0;
        t = perm(64'h0123456789ABCDEF, 64, ip_t);
        check("t1_f_r_round1", 64'(f_r), 64'(t[31:0]));
        check("t1_busy", 64'(busy), 1);
        wait_idle();

        out_ready = 0;
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1, 64'h0123456789ABCDEF);
        in_valid = 0;
        t = perm(64'h133457799BBCDFF1, 64, pc1_t);
        check("t2_f_cd_round1", 64'(f_cd), 64'(t[55:0]));

        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("t3_done", 64'(out_valid), 1);
        hold = out_block;
        cd_hold = f_cd;
        repeat (10) begin
            tick();
            check("t3_hold", out_block, hold);
            check("t3_in_ready", 64'(in_ready), 0);
        end
        check("t3_f_cd_hold", 64'(f_cd), 64'(cd_hold));
        out_ready = 1;
        tick();
        check("t3_release_ready", 64'(in_ready), 1);
        check("t3_release_valid", 64'(out_valid), 0);

        send_rand();
        send_rand();
        in_valid = 0;
        wait_idle();

        send_rand();
        in_valid = 0;
        repeat (7) tick();
        check("t5_busy_round8", 64'(busy), 1);
        rst = 1;
        q.delete();
        tick();
        rst = 0;
        check_reset("t5");
        send_rand();
        in_valid = 0;
        wait_idle();

`ifdef DES_SEQ_ABORT_EN
        send_rand();
        in_valid = 0;
        repeat (4) tick();
        abort = 1;
        q.delete();
        tick();
        abort = 0;
        check("t6_in_ready", 64'(in_ready), 1);
        check("t6_out_valid", 64'(out_valid), 0);
        check("t6_out_block", out_block, 0);
        abort = 1;
        send_rand();
        abort = 0;
        in_valid = 0;
        check("t6_idle_abort_busy", 64'(busy), 1);
        wait_idle();
`endif

        bp = 1;
        repeat (20) begin
            send_rand();
            in_valid = 0;
            repeat ($urandom_range(0, 3)) tick();
        end
        bp = 0;
        out_ready = 1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
